video_raster_tmg_gen: RTL and testbench
=======================================

// Module: video_raster_tmg_gen
// PURPOSE
//  NTSC square-pixel raster timing generator for the overlay video path. Divides CK_i into a pixel enable.
//  Drives HCTRs/VCTRs/CK_EE to the downstream position-decode stages, such as the LED hit judge.
//  Generates active flags and H, V and composite sync, with equalizing and serration pulses in the vertical interval.
//  Progressive 262-line frame, one field type.
// PARAMETERS
//  C_CK_DIV      2    CK_i cycles per pixel, >=1 (1 => CK_EE_o tied high after reset)
//  C_H_TOTAL     390  pixels per line, even, <=512
//  C_H_ACT       320  active pixels, H 0..C_H_ACT-1
//  C_H_FP        8    front porch pixels; HSYNC starts at HS0=C_H_ACT+C_H_FP
//  C_HS_W        29   HSYNC width, pixels; equalizing pulse width = C_HS_W/2
//  C_V_TOTAL     262  lines per frame, <=512
//  C_V_ACT       240  active lines, V 0..C_V_ACT-1
//  C_V_EQ_START  243  first pre-equalizing line; C_V_EQ_START+9 <= C_V_TOTAL
// PORTS
//  CK_i         in   1  clock
//  XARST_i      in   1  async reset, active low
//  FRAME_RST_i  in   1  sync restart of raster to H=0,V=0
//  CK_EE_o      out  1  pixel enable, 1 cycle per C_CK_DIV
//  HCTRs_o      out  9  horizontal counter, 0..C_H_TOTAL-1
//  VCTRs_o      out  9  vertical counter, 0..C_V_TOTAL-1; 8-bit consumers take [7:0] gated by V_ACT_o
//  H_ACT_o      out  1  HCTRs_o < C_H_ACT
//  V_ACT_o      out  1  VCTRs_o < C_V_ACT
//  XHSYNC_o     out  1  H sync, active low
//  XVSYNC_o     out  1  V sync, active low, lines C_V_EQ_START+3..+5
//  XCSYNC_o     out  1  composite sync, active low
//  FRAMEs_o     out  8  frame count; present only with VIDEO_TMG_FRAME_CTR_EN
// BEHAVIOUR
//  Reset values:
//   - all counters, CK_EE_o, H_ACT_o, V_ACT_o and FRAMEs_o = 0
//   - XHSYNC_o, XVSYNC_o and XCSYNC_o = 1
//   - divider = 0, V state = S_ACT
//  Divider:
//   - DIVs counts 0..C_CK_DIV-1
//   - CK_EE_o=1 registered exactly while DIVs==C_CK_DIV-1
//  Counters:
//   - Hold stable for the whole pixel period. Update on the edge closing a CK_EE_o=1 cycle.
//   - A consumer sampling on CK_EE sees the pixel's values.
//  Wrap: HCTRs C_H_TOTAL-1 -> 0 with VCTRs+1; at VCTRs=C_V_TOTAL-1 -> 0.
//  Sync and active outputs:
//   - Registered, decoded from next-state counters.
//   - They change on the same edge as HCTRs/VCTRs. Zero relative latency.
//  V state FSM, advanced at line wrap:
//   - S_ACT(V<C_V_ACT) -> S_VBLK -> S_PREEQ(3 lines) -> S_VSYNC(3) -> S_POSTEQ(3) -> S_VBLK -> S_ACT at V=0.
//  XCSYNC_o per state, HALF=C_H_TOTAL/2:
//   - S_ACT, S_VBLK: =XHSYNC_o, low for H in [HS0, HS0+C_HS_W).
//   - S_PREEQ, S_POSTEQ: low for C_HS_W/2 starting at HS0 and at (HS0+HALF) mod C_H_TOTAL.
//   - S_VSYNC: low from each half-line start until C_HS_W before the next, i.e. serration.
//   - HS0+C_HS_W may wrap past C_H_TOTAL; compare mod C_H_TOTAL.
//  XHSYNC_o pulses every line, including during the vertical interval.
//  FRAME_RST_i:
//   - sampled every CK_i; wins over all counting
//   - next cycle: DIVs=0, H=0, V=0, state S_ACT, CK_EE_o=0
//   - outputs decoded for H=0,V=0
//  Async reset mid-line: immediate return to reset values; restart from H=0,V=0 after release.
//  Arithmetic: all compares unsigned; the half-line offset is computed in 10 bits, then reduced modulo C_H_TOTAL.
// CONFIGURATION
//  VIDEO_TMG_FRAME_CTR_EN defined:
//   - FRAMEs_o increments (mod 256) on the wrap from V=C_V_TOTAL-1,H=C_H_TOTAL-1
//   - cleared by FRAME_RST_i
//  Not defined: port absent, no counter logic.
// STRUCTURE
//  Shared package/define.vh:
//   - V state encodings S_ACT..S_POSTEQ, 3-bit localparams
//   - default NTSC timing constants, shared with the overlay judges
//  Sub-module video_tmg_hsync_dec:
//   - combinational
//   - inputs: next H, state
//   - output: XHSYNC/XCSYNC next values
//  Everything else inline.
// TESTING
//  1. Reset, then release with defaults -> first CK_EE_o on cycle 2. H steps 0,1,2 every 2 CK. XHSYNC_o low for H=328..356.
//  2. Run to H=389,V=239 -> next pixel H=0,V=240, V_ACT_o=0, state S_VBLK.
//  3. Line 243 (S_PREEQ) -> XCSYNC_o low for H=328..341 and H=133..146 (the second pulse is (328+195) mod 390).
//  4. Line 246 (S_VSYNC) -> XCSYNC_o high only for H=299..327 and H=104..132. XVSYNC_o low on lines 246..248.
//  5. Assert FRAME_RST_i at H=200,V=100, mid pixel period -> next cycle H=0,V=0,DIVs=0,CK_EE_o=0. Raster resumes normally.
//  6. With VIDEO_TMG_FRAME_CTR_EN, run 257 frames -> FRAMEs_o=1 after wrap. C_CK_DIV=1 -> CK_EE_o stays 1 after reset, H steps every CK.

Source files
------------

// File: rtl/video_raster_tmg_gen_pkg.sv
// Shared definitions for the NTSC raster timing generator and the overlay
// judges that decode its counters: V state encodings, default timing and
// a modular window helper.
package video_raster_tmg_gen_pkg;

  // Vertical interval states, advanced once per line.
  typedef enum logic [2:0] {
    S_ACT    = 3'd0,
    S_VBLK   = 3'd1,
    S_PREEQ  = 3'd2,
    S_VSYNC  = 3'd3,
    S_POSTEQ = 3'd4
  } v_state_t;

  // Default NTSC square-pixel timing.
  localparam int NTSC_CK_DIV     = 2;
  localparam int NTSC_H_TOTAL    = 390;
  localparam int NTSC_H_ACT      = 320;
  localparam int NTSC_H_FP       = 8;
  localparam int NTSC_HS_W       = 29;
  localparam int NTSC_V_TOTAL    = 262;
  localparam int NTSC_V_ACT      = 240;
  localparam int NTSC_V_EQ_START = 243;

  // True when h lies in [start, start+len) taken modulo total.
  function automatic logic in_win(input logic [9:0] h, input logic [9:0] start,
                                  input logic [9:0] len, input logic [9:0] total);
    logic [9:0] d;
    d = (h >= start) ? (h - start) : (h + total - start);
    return (d < len);
  endfunction

endpackage

// File: rtl/video_raster_tmg_gen_if.sv
// Raster timing bundle from the generator to downstream position decoders.
// FRAMEs_o exists only when VIDEO_TMG_FRAME_CTR_EN is defined.
interface video_raster_tmg_gen_if;
  logic       CK_EE_o;
  logic [8:0] HCTRs_o;
  logic [8:0] VCTRs_o;
  logic       H_ACT_o;
  logic       V_ACT_o;
  logic       XHSYNC_o;
  logic       XVSYNC_o;
  logic       XCSYNC_o;
`ifdef VIDEO_TMG_FRAME_CTR_EN
  logic [7:0] FRAMEs_o;
`endif

  modport master (
    output CK_EE_o, HCTRs_o, VCTRs_o, H_ACT_o, V_ACT_o, XHSYNC_o, XVSYNC_o, XCSYNC_o
`ifdef VIDEO_TMG_FRAME_CTR_EN
    , output FRAMEs_o
`endif
  );

  modport slave (
    input CK_EE_o, HCTRs_o, VCTRs_o, H_ACT_o, V_ACT_o, XHSYNC_o, XVSYNC_o, XCSYNC_o
`ifdef VIDEO_TMG_FRAME_CTR_EN
    , input FRAMEs_o
`endif
  );
endinterface

// File: rtl/video_raster_tmg_gen_hsync_dec.sv
// Combinational decode of the next horizontal/composite sync levels from the
// next H position and next V state. Window starts are reduced modulo the
// line length so pulses may straddle the line wrap.
module video_tmg_hsync_dec
  import video_raster_tmg_gen_pkg::*;
#(
  parameter int C_H_TOTAL = NTSC_H_TOTAL,
  parameter int C_H_ACT   = NTSC_H_ACT,
  parameter int C_H_FP    = NTSC_H_FP,
  parameter int C_HS_W    = NTSC_HS_W
) (
  input  logic [8:0] h_next,
  input  v_state_t   state_next,
  output logic       xhsync_next,
  output logic       xcsync_next
);
  localparam logic [9:0] TOTAL   = 10'(C_H_TOTAL);
  localparam logic [9:0] HALF    = 10'(C_H_TOTAL / 2);
  localparam logic [9:0] HS0     = 10'((C_H_ACT + C_H_FP) % C_H_TOTAL);
  // Second half-line start: summed in 10 bits, then folded back into the line.
  localparam logic [9:0] HS1_SUM = HS0 + HALF;
  localparam logic [9:0] HS1     = (HS1_SUM >= TOTAL) ? (HS1_SUM - TOTAL) : HS1_SUM;
  localparam logic [9:0] HS_W    = 10'(C_HS_W);
  localparam logic [9:0] EQ_W    = 10'(C_HS_W / 2);
  // Serration: low from a half-line start until C_HS_W before the next one.
  localparam logic [9:0] SER_W   = HALF - HS_W;

  logic [9:0] h10;
  logic       in_hs;
  logic       in_eq;
  logic       in_ser;

  // Window membership and per-state selection of the composite sync level.
  always_comb begin
    h10    = {1'b0, h_next};
    in_hs  = in_win(h10, HS0, HS_W, TOTAL);
    in_eq  = in_win(h10, HS0, EQ_W, TOTAL) || in_win(h10, HS1, EQ_W, TOTAL);
    in_ser = in_win(h10, HS0, SER_W, TOTAL) || in_win(h10, HS1, SER_W, TOTAL);
    xhsync_next = ~in_hs;
    case (state_next)
      S_PREEQ, S_POSTEQ: xcsync_next = ~in_eq;
      S_VSYNC:           xcsync_next = ~in_ser;
      default:           xcsync_next = ~in_hs;
    endcase
  end
endmodule

// File: rtl/video_raster_tmg_gen.sv
// NTSC square-pixel raster timing generator: pixel-enable divider, H/V
// counters, vertical interval FSM and registered active/sync flags decoded
// from the next counter state so they move on the same edge as the counters.
// Optional frame counter: define VIDEO_TMG_FRAME_CTR_EN.
module video_raster_tmg_gen
  import video_raster_tmg_gen_pkg::*;
#(
  parameter int C_CK_DIV     = NTSC_CK_DIV,
  parameter int C_H_TOTAL    = NTSC_H_TOTAL,
  parameter int C_H_ACT      = NTSC_H_ACT,
  parameter int C_H_FP       = NTSC_H_FP,
  parameter int C_HS_W       = NTSC_HS_W,
  parameter int C_V_TOTAL    = NTSC_V_TOTAL,
  parameter int C_V_ACT      = NTSC_V_ACT,
  parameter int C_V_EQ_START = NTSC_V_EQ_START
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic                  FRAME_RST_i,
  video_raster_tmg_gen_if.master tmg
);
  localparam int               DIV_W    = (C_CK_DIV > 1) ? $clog2(C_CK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_CK_DIV - 1);
  localparam logic [8:0]       H_LAST   = 9'(C_H_TOTAL - 1);
  localparam logic [8:0]       V_LAST   = 9'(C_V_TOTAL - 1);
  localparam logic [8:0]       H_ACT_N  = 9'(C_H_ACT);
  localparam logic [8:0]       V_ACT_N  = 9'(C_V_ACT);
  localparam logic [8:0]       V_PREEQ  = 9'(C_V_EQ_START);
  localparam logic [8:0]       V_VSYNC  = 9'(C_V_EQ_START + 3);
  localparam logic [8:0]       V_POSTEQ = 9'(C_V_EQ_START + 6);
  localparam logic [8:0]       V_BLK2   = 9'(C_V_EQ_START + 9);

  logic [DIV_W-1:0] div_reg, div_next;
  logic             ck_ee_reg, ck_ee_next;
  logic [8:0]       h_reg, h_next;
  logic [8:0]       v_reg, v_next;
  logic             line_end;
  v_state_t         state_reg, state_next;
  logic             h_act_reg, h_act_next;
  logic             v_act_reg, v_act_next;
  logic             xhs_reg, xhs_next;
  logic             xvs_reg, xvs_next;
  logic             xcs_reg, xcs_next;

  // Divider and counters advance only on the cycle that closes a pixel;
  // a frame restart overrides everything.
  always_comb begin
    div_next   = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    ck_ee_next = (div_next == DIV_LAST);
    line_end   = (h_reg == H_LAST);
    h_next     = h_reg;
    v_next     = v_reg;
    if (ck_ee_reg) begin
      h_next = line_end ? 9'd0 : h_reg + 9'd1;
      if (line_end) v_next = (v_reg == V_LAST) ? 9'd0 : v_reg + 9'd1;
    end
    if (FRAME_RST_i) begin
      div_next   = '0;
      ck_ee_next = 1'b0;
      h_next     = 9'd0;
      v_next     = 9'd0;
    end
  end

  // Vertical interval next state, evaluated at the line wrap.
  always_comb begin
    state_next = state_reg;
    if (ck_ee_reg && line_end) begin
      case (state_reg)
        S_ACT:    if (v_next == V_ACT_N) state_next = S_VBLK;
        S_VBLK: begin
          if (v_next == 9'd0)         state_next = S_ACT;
          else if (v_next == V_PREEQ) state_next = S_PREEQ;
        end
        S_PREEQ:  if (v_next == V_VSYNC)  state_next = S_VSYNC;
        S_VSYNC:  if (v_next == V_POSTEQ) state_next = S_POSTEQ;
        S_POSTEQ: begin
          if (v_next == 9'd0)         state_next = S_ACT;
          else if (v_next == V_BLK2)  state_next = S_VBLK;
        end
        default:  state_next = S_ACT;
      endcase
    end
    if (FRAME_RST_i) state_next = S_ACT;
  end

  video_tmg_hsync_dec #(
    .C_H_TOTAL (C_H_TOTAL),
    .C_H_ACT   (C_H_ACT),
    .C_H_FP    (C_H_FP),
    .C_HS_W    (C_HS_W)
  ) u_hsync_dec (
    .h_next      (h_next),
    .state_next  (state_next),
    .xhsync_next (xhs_next),
    .xcsync_next (xcs_next)
  );

  // Active flags and vertical sync decoded from the next raster position.
  always_comb begin
    h_act_next = (h_next < H_ACT_N);
    v_act_next = (v_next < V_ACT_N);
    xvs_next   = (state_next != S_VSYNC);
  end

  // V state register.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) state_reg <= S_ACT;
    else          state_reg <= state_next;
  end

  // Divider, counters and registered timing flags.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      div_reg   <= '0;
      ck_ee_reg <= 1'b0;
      h_reg     <= 9'd0;
      v_reg     <= 9'd0;
      h_act_reg <= 1'b0;
      v_act_reg <= 1'b0;
      xhs_reg   <= 1'b1;
      xvs_reg   <= 1'b1;
      xcs_reg   <= 1'b1;
    end else begin
      div_reg   <= div_next;
      ck_ee_reg <= ck_ee_next;
      h_reg     <= h_next;
      v_reg     <= v_next;
      h_act_reg <= h_act_next;
      v_act_reg <= v_act_next;
      xhs_reg   <= xhs_next;
      xvs_reg   <= xvs_next;
      xcs_reg   <= xcs_next;
    end
  end

  assign tmg.CK_EE_o  = ck_ee_reg;
  assign tmg.HCTRs_o  = h_reg;
  assign tmg.VCTRs_o  = v_reg;
  assign tmg.H_ACT_o  = h_act_reg;
  assign tmg.V_ACT_o  = v_act_reg;
  assign tmg.XHSYNC_o = xhs_reg;
  assign tmg.XVSYNC_o = xvs_reg;
  assign tmg.XCSYNC_o = xcs_reg;

`ifdef VIDEO_TMG_FRAME_CTR_EN
  logic [7:0] frame_reg, frame_next;

  // Frame count bumps on the last-pixel-of-frame wrap; restart clears it.
  always_comb begin
    frame_next = frame_reg;
    if (ck_ee_reg && line_end && (v_reg == V_LAST)) frame_next = frame_reg + 8'd1;
    if (FRAME_RST_i) frame_next = 8'd0;
  end

  // Frame count register.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) frame_reg <= 8'd0;
    else          frame_reg <= frame_next;
  end

  assign tmg.FRAMEs_o = frame_reg;
`endif
endmodule

// File: tb/tb_video_raster_tmg_gen.sv
// Testbench for video_raster_tmg_gen. Main instance: default H timing,
// C_CK_DIV=2, shortened 30-line frame. Second instance: C_CK_DIV=1 with a
// tiny raster, used for the divide-by-one and frame counter cases.
module tb_video_raster_tmg_gen;

  logic clk = 1'b0;
  logic XARST_i;
  logic FRAME_RST_i;

  always #5 clk = ~clk;

  video_raster_tmg_gen_if tmg ();
  video_raster_tmg_gen_if tmg1 ();

  video_raster_tmg_gen #(
    .C_CK_DIV(2), .C_H_TOTAL(390), .C_H_ACT(320), .C_H_FP(8), .C_HS_W(29),
    .C_V_TOTAL(30), .C_V_ACT(16), .C_V_EQ_START(19)
  ) dut (
    .CK_i(clk), .XARST_i(XARST_i), .FRAME_RST_i(FRAME_RST_i), .tmg(tmg)
  );

  video_raster_tmg_gen #(
    .C_CK_DIV(1), .C_H_TOTAL(10), .C_H_ACT(4), .C_H_FP(1), .C_HS_W(2),
    .C_V_TOTAL(12), .C_V_ACT(2), .C_V_EQ_START(3)
  ) dut1 (
    .CK_i(clk), .XARST_i(XARST_i), .FRAME_RST_i(1'b0), .tmg(tmg1)
  );

  // exp = {H_ACT, V_ACT, XHSYNC, XVSYNC, XCSYNC} at pixel (v,h)
  typedef struct {
    int         v;
    int         h;
    logic [4:0] exp;
  } vec_t;

  localparam int NV = 36;
  vec_t tbl [NV];
  vec_t sb [$];
  vec_t head;
  logic [4:0] act;

  int total = 0;
  int bad = 0;
  bit dut1_done = 1'b0;

  function automatic logic [31:0] snap();
    return 32'({tmg.CK_EE_o, tmg.HCTRs_o, tmg.VCTRs_o,
                tmg.H_ACT_o, tmg.V_ACT_o, tmg.XHSYNC_o, tmg.XVSYNC_o, tmg.XCSYNC_o});
  endfunction

  function automatic logic [31:0] snap1();
    return 32'({tmg1.CK_EE_o, tmg1.HCTRs_o, tmg1.VCTRs_o});
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end else begin
      $display("check %s ok (%h)", name, got);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, %0d vectors left, next v=%0d h=%0d",
               name, sb.size(), sb[0].v, sb[0].h);
      sb.delete();
    end
  endtask

  // Scoreboard consumer: compare when the DUT reaches the head pixel.
  always @(negedge clk) begin
    if (sb.size() > 0 && tmg.CK_EE_o === 1'b1 &&
        int'(tmg.VCTRs_o) == sb[0].v && int'(tmg.HCTRs_o) == sb[0].h) begin
      head = sb.pop_front();
      act = {tmg.H_ACT_o, tmg.V_ACT_o, tmg.XHSYNC_o, tmg.XVSYNC_o, tmg.XCSYNC_o};
      total++;
      if (act !== head.exp) begin
        bad++;
        $display("FAIL vec v=%0d h=%0d: got=%b want=%b", head.v, head.h, act, head.exp);
      end else begin
        $display("vec v=%0d h=%0d flags=%b ok", head.v, head.h, act);
      end
    end
  end

  // Main instance: reset, start-up, table of raster points, frame restart,
  // asynchronous reset mid-line.
  initial begin
    int n;
    bit found;
    tbl[0]  = '{0, 319, 5'b11111};
    tbl[1]  = '{0, 320, 5'b01111};
    tbl[2]  = '{0, 327, 5'b01111};
    tbl[3]  = '{0, 328, 5'b01010};
    tbl[4]  = '{0, 356, 5'b01010};
    tbl[5]  = '{0, 357, 5'b01111};
    tbl[6]  = '{0, 389, 5'b01111};
    tbl[7]  = '{1, 0,   5'b11111};
    tbl[8]  = '{15, 389, 5'b01111};
    tbl[9]  = '{16, 0,   5'b10111};
    tbl[10] = '{16, 342, 5'b00010};
    tbl[11] = '{19, 132, 5'b10111};
    tbl[12] = '{19, 133, 5'b10110};
    tbl[13] = '{19, 146, 5'b10110};
    tbl[14] = '{19, 147, 5'b10111};
    tbl[15] = '{19, 328, 5'b00010};
    tbl[16] = '{19, 341, 5'b00010};
    tbl[17] = '{19, 342, 5'b00011};
    tbl[18] = '{22, 0,   5'b10100};
    tbl[19] = '{22, 103, 5'b10100};
    tbl[20] = '{22, 104, 5'b10101};
    tbl[21] = '{22, 132, 5'b10101};
    tbl[22] = '{22, 133, 5'b10100};
    tbl[23] = '{22, 298, 5'b10100};
    tbl[24] = '{22, 299, 5'b10101};
    tbl[25] = '{22, 327, 5'b00101};
    tbl[26] = '{22, 328, 5'b00000};
    tbl[27] = '{24, 389, 5'b00100};
    tbl[28] = '{25, 0,   5'b10111};
    tbl[29] = '{25, 133, 5'b10110};
    tbl[30] = '{25, 147, 5'b10111};
    tbl[31] = '{25, 342, 5'b00011};
    tbl[32] = '{28, 133, 5'b10111};
    tbl[33] = '{28, 342, 5'b00010};
    tbl[34] = '{29, 389, 5'b00111};
    tbl[35] = '{0, 0,    5'b11111};

    XARST_i = 1'b0;
    FRAME_RST_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset", snap(), 32'({1'b0, 9'd0, 9'd0, 5'b00111}));
    chk("reset_div1", snap1(), 32'd0);

    XARST_i = 1'b1;
    @(negedge clk); chk("start_h0_ee", snap(), 32'({1'b1, 9'd0, 9'd0, 5'b11111}));
    @(negedge clk); chk("start_h1", snap(), 32'({1'b0, 9'd1, 9'd0, 5'b11111}));
    @(negedge clk); chk("start_h1_ee", snap(), 32'({1'b1, 9'd1, 9'd0, 5'b11111}));
    @(negedge clk); chk("start_h2", snap(), 32'({1'b0, 9'd2, 9'd0, 5'b11111}));

    for (int i = 0; i < NV; i++) sb.push_back(tbl[i]);
    drain("frame_table", 30000);

    // Frame restart in the first half of pixel H=200 on line 10.
    found = 1'b0;
    n = 0;
    while (!found && n < 20000) begin
      @(negedge clk);
      n++;
      if (tmg.CK_EE_o === 1'b0 && tmg.HCTRs_o == 9'd200 && tmg.VCTRs_o == 9'd10) found = 1'b1;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL frst_find: got=timeout want=H200 V10");
    end else begin
`ifdef VIDEO_TMG_FRAME_CTR_EN
      chk("frames_before_frst", 32'(tmg.FRAMEs_o), 32'd1);
`endif
      FRAME_RST_i = 1'b1;
      @(negedge clk);
      FRAME_RST_i = 1'b0;
      chk("frst_0", snap(), 32'({1'b0, 9'd0, 9'd0, 5'b11111}));
`ifdef VIDEO_TMG_FRAME_CTR_EN
      chk("frames_after_frst", 32'(tmg.FRAMEs_o), 32'd0);
`endif
      @(negedge clk); chk("frst_1", snap(), 32'({1'b1, 9'd0, 9'd0, 5'b11111}));
      @(negedge clk); chk("frst_2", snap(), 32'({1'b0, 9'd1, 9'd0, 5'b11111}));
      sb.push_back('{0, 327, 5'b01111});
      sb.push_back('{0, 328, 5'b01010});
      sb.push_back('{0, 357, 5'b01111});
      sb.push_back('{1, 0,   5'b11111});
      drain("after_frst", 2000);
    end

    n = 0;
    while (!dut1_done && n < 50000) begin
      @(negedge clk);
      n++;
    end
    if (!dut1_done) begin
      total++;
      bad++;
      $display("FAIL div1_wait: got=timeout want=done");
    end

    // Asynchronous reset between clock edges, mid-line.
    @(posedge clk);
    #2 XARST_i = 1'b0;
    #1 chk("arst_now", snap(), 32'({1'b0, 9'd0, 9'd0, 5'b00111}));
    @(negedge clk);
    XARST_i = 1'b1;
    @(negedge clk); chk("arst_h0_ee", snap(), 32'({1'b1, 9'd0, 9'd0, 5'b11111}));
    @(negedge clk); chk("arst_h1", snap(), 32'({1'b0, 9'd1, 9'd0, 5'b11111}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Divide-by-one instance: enable stays high, H steps every clock,
  // and (when built in) the frame counter wraps modulo 256.
  initial begin
    wait (XARST_i === 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("div1_k%0d", k), snap1(),
          32'({1'b1, 9'((k - 1) % 10), 9'((k - 1) / 10)}));
    end
`ifdef VIDEO_TMG_FRAME_CTR_EN
    begin
      int wraps;
      int n;
      bit pend;
      bit done;
      wraps = 0;
      n = 0;
      pend = 1'b0;
      done = 1'b0;
      while (!done && n < 40000) begin
        @(negedge clk);
        n++;
        if (pend) begin
          pend = 1'b0;
          if (wraps == 1)   chk("frames_1",   32'(tmg1.FRAMEs_o), 32'd1);
          if (wraps == 255) chk("frames_255", 32'(tmg1.FRAMEs_o), 32'd255);
          if (wraps == 256) chk("frames_256", 32'(tmg1.FRAMEs_o), 32'd0);
          if (wraps == 257) begin
            chk("frames_257", 32'(tmg1.FRAMEs_o), 32'd1);
            done = 1'b1;
          end
        end
        if (tmg1.CK_EE_o === 1'b1 && tmg1.VCTRs_o == 9'd11 && tmg1.HCTRs_o == 9'd9) begin
          wraps++;
          pend = 1'b1;
        end
      end
      if (!done) begin
        total++;
        bad++;
        $display("FAIL frames_run: got=%0d wraps want=257", wraps);
      end
    end
`endif
    dut1_done = 1'b1;
  end

endmodule
